// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RV32I pipeline.
// Tracks in-flight producers, raises load-use and memory-wait stalls,
// squashes on redirects and registers the operand forwarding selects.
module hazard_controller #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [RA_W-1:0]  d_rs1,
    input  logic [RA_W-1:0]  d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [RA_W-1:0]  d_rd,
    input  logic             d_regwen,
    input  logic             d_is_load,
    input  logic             d_is_mem,
    input  logic             ex_redirect,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             freeze,
    output logic             bubble_e,
    output logic             flush_d,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // E slot needs is_load for the load-use check; M slot needs is_mem for
    // the memory wait. The W slot is never consulted: a producer in W has
    // already been folded into the registered fwd select of its consumer,
    // so the instruction leaving M is simply dropped.
    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwen;
        logic            is_load;
        logic            is_mem;
    } e_slot_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            regwen;
        logic            is_mem;
    } m_slot_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LU_STALL,
        ST_MEM_WAIT
    } state_t;

    state_t            state_reg, state_next;
    e_slot_t           e_reg, e_next;
    m_slot_t           m_reg, m_next;
    logic [1:0]        fwd_a_reg, fwd_a_next;
    logic [1:0]        fwd_b_reg, fwd_b_next;
    logic [CNT_W-1:0]  stall_cycles_reg;
    logic [CNT_W-1:0]  flush_count_reg;
    logic              stall_inc, flush_inc;
    logic              stall_f_c, stall_d_c, freeze_c, bubble_e_c, flush_d_c;

    // A slot produces a source when it writes a non-zero register equal to it.
    function automatic logic hit(input logic valid, input logic regwen,
                                 input logic [RA_W-1:0] rd,
                                 input logic [RA_W-1:0] src,
                                 input logic use_src);
        return valid && regwen && (rd == src) && (rd != '0) && use_src;
    endfunction

    logic e_hit_rs1, e_hit_rs2, m_hit_rs1, m_hit_rs2;
    logic mem_wait, load_use;

    assign e_hit_rs1 = hit(e_reg.valid, e_reg.regwen, e_reg.rd, d_rs1, d_use_rs1);
    assign e_hit_rs2 = hit(e_reg.valid, e_reg.regwen, e_reg.rd, d_rs2, d_use_rs2);
    assign m_hit_rs1 = hit(m_reg.valid, m_reg.regwen, m_reg.rd, d_rs1, d_use_rs1);
    assign m_hit_rs2 = hit(m_reg.valid, m_reg.regwen, m_reg.rd, d_rs2, d_use_rs2);

    assign mem_wait = m_reg.valid && m_reg.is_mem && !dmem_ready;
    // Right after a load-use bubble E holds that bubble, so no second stall.
    assign load_use = d_valid && e_reg.valid && e_reg.is_load &&
                      (e_hit_rs1 || e_hit_rs2) && (state_reg != ST_LU_STALL);

    // Prioritised hazard resolution: memory wait, redirect, load-use, issue.
    always_comb begin
        state_next = ST_RUN;
        e_next     = e_reg;
        m_next     = m_reg;
        fwd_a_next = fwd_a_reg;
        fwd_b_next = fwd_b_reg;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        freeze_c   = 1'b0;
        bubble_e_c = 1'b0;
        flush_d_c  = 1'b0;
        if (mem_wait) begin
            freeze_c   = 1'b1;
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            stall_inc  = 1'b1;
            state_next = ST_MEM_WAIT;
        end else begin
            m_next = '{valid: e_reg.valid, rd: e_reg.rd,
                       regwen: e_reg.regwen, is_mem: e_reg.is_mem};
            if (ex_redirect) begin
                flush_d_c  = 1'b1;
                bubble_e_c = 1'b1;
                flush_inc  = 1'b1;
                e_next     = '0;
                fwd_a_next = 2'b00;
                fwd_b_next = 2'b00;
            end else if (load_use) begin
                stall_f_c  = 1'b1;
                stall_d_c  = 1'b1;
                bubble_e_c = 1'b1;
                stall_inc  = 1'b1;
                e_next     = '0;
                fwd_a_next = 2'b00;
                fwd_b_next = 2'b00;
                state_next = ST_LU_STALL;
            end else begin
                e_next = '{valid: d_valid, rd: d_rd, regwen: d_regwen,
                           is_load: d_is_load, is_mem: d_is_mem};
                // Youngest producer wins; a decode bubble carries no operands.
                fwd_a_next = !d_valid ? 2'b00 : e_hit_rs1 ? 2'b01 :
                             m_hit_rs1 ? 2'b10 : 2'b00;
                fwd_b_next = !d_valid ? 2'b00 : e_hit_rs2 ? 2'b01 :
                             m_hit_rs2 ? 2'b10 : 2'b00;
            end
        end
    end

    // Pipeline state, scoreboard slots and forwarding selects.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
            e_reg     <= '0;
            m_reg     <= '0;
            fwd_a_reg <= 2'b00;
            fwd_b_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            e_reg     <= e_next;
            m_reg     <= m_next;
            fwd_a_reg <= fwd_a_next;
            fwd_b_reg <= fwd_b_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (stall_inc && (stall_cycles_reg != '1))
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            if (flush_inc && (flush_count_reg != '1))
                flush_count_reg <= flush_count_reg + 1'b1;
        end
    end

    // Control outputs are quiet while reset is held, whatever E presents.
    assign stall_f      = reset & stall_f_c;
    assign stall_d      = reset & stall_d_c;
    assign freeze       = reset & freeze_c;
    assign bubble_e     = reset & bubble_e_c;
    assign flush_d      = reset & flush_d_c;
    assign fwd_a        = fwd_a_reg;
    assign fwd_b        = fwd_b_reg;
    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: an instruction-level pipeline model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_hazard_controller;

    localparam int RA_W  = 5;
    localparam int CNT_W = 16;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             d_valid = 1'b0;
    logic [RA_W-1:0]  d_rs1 = '0, d_rs2 = '0, d_rd = '0;
    logic             d_use_rs1 = 1'b0, d_use_rs2 = 1'b0;
    logic             d_regwen = 1'b0, d_is_load = 1'b0, d_is_mem = 1'b0;
    logic             ex_redirect = 1'b0;
    logic             dmem_ready = 1'b1;
    logic             stall_f, stall_d, freeze, bubble_e, flush_d;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks = 0;
    int failures = 0;

    hazard_controller #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .d_rd(d_rd), .d_regwen(d_regwen), .d_is_load(d_is_load), .d_is_mem(d_is_mem),
        .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .freeze(freeze), .bubble_e(bubble_e),
        .flush_d(flush_d), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    typedef struct {
        bit v;
        int rd;
        bit wen;
        bit ld;
        bit mem;
    } ent_t;

    // pipe[0] = instruction in E, pipe[1] = in M, pipe[2] = in W
    ent_t pipe[3];
    int   m_fa = 0, m_fb = 0;
    int   n_stall = 0, n_flush = 0;

    localparam int A_FREEZE = 0, A_FLUSH = 1, A_LU = 2, A_ISSUE = 3;

    function automatic bit produces(ent_t s, int src, bit use_src);
        return use_src && s.v && s.wen && s.rd != 0 && s.rd == src;
    endfunction

    function automatic int action();
        if (pipe[1].v && pipe[1].mem && !dmem_ready) return A_FREEZE;
        if (ex_redirect) return A_FLUSH;
        if (d_valid && pipe[0].v && pipe[0].ld &&
            (produces(pipe[0], int'(d_rs1), d_use_rs1) ||
             produces(pipe[0], int'(d_rs2), d_use_rs2))) return A_LU;
        return A_ISSUE;
    endfunction

    // Distance to the nearest producer when the consumer reaches E:
    // producer then in M -> 01, in W -> 10, further away -> regfile.
    function automatic int fsel(int src, bit use_src);
        if (!d_valid) return 0;
        for (int k = 0; k < 2; k++)
            if (produces(pipe[k], src, use_src)) return k + 1;
        return 0;
    endfunction

    function automatic int sat(int n);
        return (n > SAT) ? SAT : n;
    endfunction

    always @(posedge clock or negedge reset) begin : model
        ent_t nx[3];
        int   a, fa, fb;
        if (!reset) begin
            for (int k = 0; k < 3; k++) pipe[k] <= '{0, 0, 0, 0, 0};
            m_fa <= 0; m_fb <= 0; n_stall <= 0; n_flush <= 0;
        end else begin
            a = action();
            nx = pipe;
            fa = m_fa; fb = m_fb;
            if (a != A_FREEZE) begin
                nx[2] = pipe[1];
                nx[1] = pipe[0];
                nx[0] = '{0, 0, 0, 0, 0};
                fa = 0; fb = 0;
                if (a == A_ISSUE) begin
                    fa = fsel(int'(d_rs1), d_use_rs1);
                    fb = fsel(int'(d_rs2), d_use_rs2);
                    nx[0] = '{d_valid, int'(d_rd), d_regwen, d_is_load, d_is_mem};
                end
            end
            pipe <= nx;
            m_fa <= fa; m_fb <= fb;
            if (a == A_FREEZE || a == A_LU) n_stall <= n_stall + 1;
            if (a == A_FLUSH) n_flush <= n_flush + 1;
        end
    end

    // Compare every DUT output against the model each cycle.
    always @(negedge clock) begin : compare
        int a;
        a = action();
        if (!reset) a = -1;
        chk("stall_f",  int'(stall_f),  int'(a == A_FREEZE || a == A_LU));
        chk("stall_d",  int'(stall_d),  int'(a == A_FREEZE || a == A_LU));
        chk("freeze",   int'(freeze),   int'(a == A_FREEZE));
        chk("bubble_e", int'(bubble_e), int'(a == A_FLUSH || a == A_LU));
        chk("flush_d",  int'(flush_d),  int'(a == A_FLUSH));
        chk("fwd_a", int'(fwd_a), m_fa);
        chk("fwd_b", int'(fwd_b), m_fb);
        chk("stall_cycles", int'(stall_cycles), sat(n_stall));
        chk("flush_count",  int'(flush_count),  sat(n_flush));
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit v;
        int rd, rs1, rs2;
        bit u1, u2, wen, ld, mem;
    } ins_t;

    function automatic ins_t nop();
        return '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    endfunction
    function automatic ins_t alu(int rd, int rs1, int rs2, bit u2);
        return '{1, rd, rs1, rs2, 1, u2, 1, 0, 0};
    endfunction
    function automatic ins_t lw(int rd, int rs1);
        return '{1, rd, rs1, 0, 1, 0, 1, 1, 1};
    endfunction
    function automatic ins_t sw(int rs1, int rs2);
        return '{1, 0, rs1, rs2, 1, 1, 0, 0, 1};
    endfunction

    // Apply one cycle of decode inputs; returns mid low phase, after compare.
    task automatic step(input ins_t i, input bit redir, input bit rdy);
        @(posedge clock); #1;
        d_valid = i.v; d_rd = RA_W'(i.rd); d_rs1 = RA_W'(i.rs1); d_rs2 = RA_W'(i.rs2);
        d_use_rs1 = i.u1; d_use_rs2 = i.u2; d_regwen = i.wen;
        d_is_load = i.ld; d_is_mem = i.mem;
        ex_redirect = redir; dmem_ready = rdy;
        @(negedge clock); #1;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_stall_f", int'(stall_f), 0);
        chk("rst_fwd_a", int'(fwd_a), 0);
        chk("rst_stall_cycles", int'(stall_cycles), 0);
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b1;

        // ALU forwarding: back-to-back -> 01, one gap -> 10, x0 -> 00
        step(alu(5, 1, 0, 0), 0, 1);
        chk("first_issue_stall_f", int'(stall_f), 0);
        step(alu(6, 5, 5, 1), 0, 1);
        chk("b2b_no_stall", int'(stall_d), 0);
        step(nop(), 0, 1);
        chk("b2b_fwd_a", int'(fwd_a), 1);
        chk("b2b_fwd_b", int'(fwd_b), 1);
        step(alu(10, 2, 0, 0), 0, 1);
        step(nop(), 0, 1);
        step(alu(11, 10, 3, 1), 0, 1);
        step(nop(), 0, 1);
        chk("gap_fwd_a", int'(fwd_a), 2);
        chk("gap_fwd_b", int'(fwd_b), 0);
        step(alu(0, 2, 0, 0), 0, 1);
        step(alu(12, 0, 0, 1), 0, 1);
        step(nop(), 0, 1);
        chk("x0_fwd_a", int'(fwd_a), 0);

        // Load-use: one bubble, then W forward
        step(lw(7, 2), 0, 1);
        step(alu(8, 7, 1, 1), 0, 1);
        chk("lu_stall_f", int'(stall_f), 1);
        chk("lu_stall_d", int'(stall_d), 1);
        chk("lu_bubble_e", int'(bubble_e), 1);
        step(alu(8, 7, 1, 1), 0, 1);
        chk("lu_retry_no_stall", int'(stall_f), 0);
        step(nop(), 0, 1);
        chk("lu_fwd_a", int'(fwd_a), 2);
        chk("lu_fwd_b", int'(fwd_b), 0);
        chk("lu_stall_cycles", int'(stall_cycles), 1);

        // Redirect overrides load-use
        step(lw(7, 2), 0, 1);
        step(alu(8, 7, 1, 1), 1, 1);
        chk("rd_flush_d", int'(flush_d), 1);
        chk("rd_bubble_e", int'(bubble_e), 1);
        chk("rd_stall_f", int'(stall_f), 0);
        step(nop(), 0, 1);
        chk("rd_flush_count", int'(flush_count), 1);
        chk("rd_stall_cycles", int'(stall_cycles), 1);

        // Memory wait: sw in M, ready low 3 cycles; fwd of E-instr held
        step(alu(13, 2, 0, 0), 0, 1);
        step(sw(2, 13), 0, 1);
        step(alu(14, 13, 0, 0), 0, 1);
        for (int n = 0; n < 3; n++) begin
            step(nop(), 0, 0);
            chk("mw_freeze", int'(freeze), 1);
            chk("mw_stall_f", int'(stall_f), 1);
            chk("mw_fwd_hold", int'(fwd_a), 2);
        end
        step(nop(), 0, 1);
        chk("mw_release", int'(freeze), 0);
        chk("mw_stall_cycles", int'(stall_cycles), 4);

        // Reset in the middle of a memory wait
        step(sw(2, 3), 0, 1);
        step(nop(), 0, 1);
        step(nop(), 0, 0);
        chk("pre_rst_freeze", int'(freeze), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_freeze", int'(freeze), 0);
        chk("mid_rst_stall_d", int'(stall_d), 0);
        chk("mid_rst_fwd_b", int'(fwd_b), 0);
        chk("mid_rst_stall_cycles", int'(stall_cycles), 0);
        chk("mid_rst_flush_count", int'(flush_count), 0);
        @(negedge clock); #1;
        reset = 1'b1;
        step(alu(20, 5, 0, 0), 0, 0);
        chk("post_rst_no_stall", int'(stall_f), 0);

        // Saturation of stall_cycles
        step(sw(2, 3), 0, 1);
        step(nop(), 0, 1);
        for (int n = 0; n < SAT + 6; n++) step(nop(), 0, 0);
        chk("sat_value", int'(stall_cycles), SAT);
        chk("sat_freeze", int'(freeze), 1);
        step(nop(), 0, 1);
        chk("sat_hold", int'(stall_cycles), SAT);
        chk("sat_release", int'(freeze), 0);

        @(posedge clock); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the 5-stage RV32I core (F, D, E, M, W). It sits beside the decode-stage control decoder and consumes the decoded rd/regwen/wbsel/memrw information.
- Keeps a 3-slot scoreboard of in-flight instructions and generates the stall, bubble, flush and forwarding-select signals.
- Freezes the pipeline while data memory is busy and counts lost cycles for performance debug.

Parameters:
- RA_W, 5, register address width
- CNT_W, 16, width of the saturating performance counters

Ports:
- clock  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- d_valid  in  1  decode stage holds a real instruction
- d_rs1  in  RA_W  decode source register 1
- d_rs2  in  RA_W  decode source register 2
- d_use_rs1  in  1  instruction reads rs1
- d_use_rs2  in  1  instruction reads rs2
- d_rd  in  RA_W  decode destination register
- d_regwen  in  1  decode regwen
- d_is_load  in  1  decode wbsel==2'b00 (load opcode)
- d_is_mem  in  1  load or store (memrw or load)
- ex_redirect  in  1  branch taken / JAL / JALR resolved in E; held stable by E while frozen
- dmem_ready  in  1  data memory completes the access presented by M this cycle
- stall_f  out  1  hold PC
- stall_d  out  1  hold F/D register
- freeze  out  1  hold D/E, E/M and M/W registers
- bubble_e  out  1  load NOP into D/E on next edge
- flush_d  out  1  load NOP into F/D on next edge
- fwd_a  out  2  registered operand-A select for instruction now in E: 00 regfile, 01 M-stage result, 10 W-stage result
- fwd_b  out  2  same for operand B
- stall_cycles  out  CNT_W  saturating count of load-use plus memory-wait cycles
- flush_count  out  CNT_W  saturating count of redirects

Behaviour:
- Reset (reset==0, async):
  - scoreboard slots E/M/W invalid; state RUN; fwd_a/fwd_b=00; counters=0.
  - All combinational outputs evaluate to 0 from this state.
- Scoreboard slot fields: {valid, rd, regwen, is_load, is_mem}.
- Match rule: a source matches a slot iff slot valid, slot regwen, rd==src, rd!=0, and the matching use bit is set.
- States:
  - RUN: normal flow.
  - LU_STALL: one-cycle load-use bubble.
  - MEM_WAIT: pipeline frozen.
- Priority each cycle, highest first:
  1. MEM_WAIT condition: M slot valid, is_mem, and dmem_ready==0.
     - Drive freeze=stall_f=stall_d=1, bubble_e=0, flush_d=0.
     - Scoreboard and fwd registers hold.
     - State becomes MEM_WAIT; stall_cycles increments.
     - Exit to RUN on the first cycle dmem_ready==1. That cycle is a normal advance cycle.
  2. ex_redirect:
     - Drive flush_d=1 and bubble_e=1; decode instruction squashed, nothing new issued.
     - Scoreboard shifts with E slot loaded invalid; flush_count increments.
     - Overrides a simultaneous load-use hazard.
  3. Load-use hazard: E slot is_load and matches either decode source, with d_valid.
     - Drive stall_f=stall_d=1 and bubble_e=1 for exactly one cycle.
     - Scoreboard shifts with E slot loaded invalid; state LU_STALL; stall_cycles increments.
     - On the next cycle the load is in M and the consumer re-evaluates: no load-use stall (W forward).
  4. Normal issue:
     - Scoreboard shifts E->M->W, and E is loaded with decode fields (valid=d_valid).
     - fwd_a/fwd_b are registered per source: E-slot match gives 01; otherwise M-slot match gives 10; otherwise 00. The youngest producer wins.
- Shift semantics: old W is discarded, M->W, E->M.
- Latency:
  - fwd_* are valid in the same cycle the consumer occupies E.
  - Stall, bubble and flush outputs are combinational from the current inputs and state.
- LU_STALL returns to RUN unconditionally unless MEM_WAIT or a redirect applies. Back-to-back loads with dependencies can each cost one bubble.
- Counters saturate at all-ones and never wrap.
- d_valid==0: treated as a bubble; no hazard raised; the slot is loaded invalid.
- Reset asserted mid-MEM_WAIT: immediate return to the reset state; the pending access is abandoned.

Test Plan:
- Reset: assert reset=0 mid-stream -> all outputs 0, fwd 00, counters 0; release -> RUN, first instruction issues without stall.
- ALU forwarding: addi x5 issued, then add x6,x5,x5 the next cycle -> no stall, fwd_a=fwd_b=01; one gap instruction -> fwd=10; rd=x0 producer -> fwd=00.
- Load-use: lw x7 then add x8,x7,x1 -> one cycle with stall_f=stall_d=bubble_e=1; consumer then in E with fwd_a=10, fwd_b=00; stall_cycles=1.
- Redirect during load-use: lw x7 followed by a dependent add, with ex_redirect=1 in the stall cycle -> flush_d=1, bubble_e=1, stall_f=0; flush_count=1; stall_cycles unchanged.
- Memory wait: sw in M with dmem_ready low for 3 cycles -> freeze/stall_f/stall_d high for exactly 3 cycles; fwd and scoreboard hold; stall_cycles +3; pipeline resumes on the ready cycle.
- Saturation: force 2^CNT_W+5 memory-wait cycles -> stall_cycles stays 16'hFFFF.
